// File: rtl/line_assembler_pkg.sv
// rtl/line_assembler_pkg.sv - shared constants and helpers for the line assembler
package line_assembler_pkg;

  // Level of rst that holds the block in reset
  localparam logic RstEnable = 1'b0;

  // Default filler value for slots that carry no real element
  localparam int NONDATA = 0;

  // Index width for a bank of n entries, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_assembler_store.sv
// rtl/line_assembler_store.sv - LINE_LEN x DATA_W register bank with indexed write and clear
module line_store
  import line_assembler_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 4,
  parameter int IDX_W    = idx_width(LINE_LEN),
  parameter logic [DATA_W-1:0] PAD = DATA_W'(NONDATA)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         clr,
  output logic [LINE_LEN*DATA_W-1:0]   line
);

  logic [DATA_W-1:0] mem [LINE_LEN];

  // Clear wins over a write: a closing line has already taken its last element
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      for (int i = 0; i < LINE_LEN; i++) mem[i] <= PAD;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Whole-line parallel read, element 0 in the LSBs
  always_comb begin
    for (int i = 0; i < LINE_LEN; i++) line[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/line_assembler.sv
// rtl/line_assembler.sv - packs an element stream into lines with ping-pong buffering and flush
module line_assembler
  import line_assembler_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 4,
  parameter logic [DATA_W-1:0] PAD = DATA_W'(NONDATA)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [LINE_LEN*DATA_W-1:0]      line_data,
  output logic [$clog2(LINE_LEN+1)-1:0]   line_count,
  output logic                            line_valid,
  input  logic                            line_ready
);

  localparam int IDX_W = idx_width(LINE_LEN);
  localparam int CNT_W = $clog2(LINE_LEN+1);

  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          wr_idx;
  logic [CNT_W-1:0]          hold_count;
  logic [LINE_LEN*DATA_W-1:0] fill_line;
  logic [LINE_LEN*DATA_W-1:0] closed_line;
  logic [CNT_W-1:0]          closed_count;
  logic                      accept, close, slot_free, drain_wait, store_we, store_clr;

  assign in_ready     = (state == FILL) && (rst != RstEnable);
  assign accept       = in_valid && in_ready;
  assign close        = (state == FILL) &&
                        ((accept && wr_idx == IDX_W'(LINE_LEN-1)) ||
                         (flush && (wr_idx != '0 || accept)));
  assign closed_count = CNT_W'(wr_idx) + CNT_W'(accept);
  assign slot_free    = !line_valid || line_ready;
  assign drain_wait   = (state == WAIT) && line_ready;
  assign store_clr    = (close && slot_free) || drain_wait;
  assign store_we     = accept;

  line_store #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .IDX_W    (IDX_W),
    .PAD      (PAD)
  ) u_fill (
    .clk   (clk),
    .rst   (rst),
    .we    (store_we),
    .widx  (wr_idx),
    .wdata (in_data),
    .clr   (store_clr),
    .line  (fill_line)
  );

  // Line as it would close this cycle, including a same-cycle accepted element
  always_comb begin
    closed_line = fill_line;
    if (accept) closed_line[int'(wr_idx)*DATA_W +: DATA_W] = in_data;
  end

  // Write index and FILL/WAIT control
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= FILL;
      wr_idx     <= '0;
      hold_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (close) begin
            wr_idx <= '0;
            if (!slot_free) begin
              state      <= WAIT;
              hold_count <= closed_count;
            end
          end else if (accept) begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
        WAIT: begin
          if (line_ready) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  // Output register: load a closing or frozen line, otherwise retire on handshake
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      line_valid <= 1'b0;
      line_data  <= {LINE_LEN{PAD}};
      line_count <= '0;
    end else if (close && slot_free) begin
      line_valid <= 1'b1;
      line_data  <= closed_line;
      line_count <= closed_count;
    end else if (drain_wait) begin
      line_valid <= 1'b1;
      line_data  <= fill_line;
      line_count <= hold_count;
    end else if (line_valid && line_ready) begin
      line_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_assembler.sv
// tb/tb_line_assembler.sv - directed vector table plus randomised scoreboard for line_assembler
module tb_line_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] line_data;
  logic [2:0]  line_count;
  logic        line_valid;
  logic        line_ready;

  int checks   = 0;
  int failures = 0;

  line_assembler #(.DATA_W(8), .LINE_LEN(4), .PAD(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .line_data  (line_data),
    .line_count (line_count),
    .line_valid (line_valid),
    .line_ready (line_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  d;
    logic        fl;
    logic        lr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [2:0]  e_count;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d,
                              input logic fl, input logic lr, input logic ev,
                              input logic [31:0] ed, input logic [2:0] ec, input logic er);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.fl = fl; v.lr = lr;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_ready = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  logic [7:0]  q[$];
  logic [31:0] exp_line;
  logic [31:0] prev_data;
  logic [2:0]  prev_count;
  logic        prev_stall;
  logic [7:0]  next_val;
  int          lines_seen;

  initial begin
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0; line_ready = 1'b0;

    // reset
    vecs.push_back(mk(0,0,8'h00,0,0, 0,32'h0,3'd0,0));
    // 1: streaming with consumer ready
    vecs.push_back(mk(1,1,8'h11,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h22,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h33,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h44,0,1, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,0,8'h00,0,1, 0,32'h44332211,3'd4,1));
    // 2: consumer stalled, second line waits, flush ignored in WAIT
    vecs.push_back(mk(1,1,8'h11,0,0, 0,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h22,0,0, 0,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h33,0,0, 0,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h44,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h55,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h66,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h77,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h88,0,0, 1,32'h44332211,3'd4,0));
    vecs.push_back(mk(1,0,8'h00,1,0, 1,32'h44332211,3'd4,0));
    vecs.push_back(mk(1,0,8'h00,0,1, 1,32'h88776655,3'd4,1));
    vecs.push_back(mk(1,0,8'h00,0,1, 0,32'h88776655,3'd4,1));
    // 3: flush alone closes a partial line, next element lands in slot 0
    vecs.push_back(mk(1,1,8'hA1,0,1, 0,32'h88776655,3'd4,1));
    vecs.push_back(mk(1,1,8'hB2,0,1, 0,32'h88776655,3'd4,1));
    vecs.push_back(mk(1,0,8'h00,1,1, 1,32'h0000B2A1,3'd2,1));
    vecs.push_back(mk(1,1,8'h05,0,1, 0,32'h0000B2A1,3'd2,1));
    vecs.push_back(mk(1,0,8'h00,1,1, 1,32'h00000005,3'd1,1));
    // 4: flush with same-cycle element, then empty flush is a no-op
    vecs.push_back(mk(1,1,8'hA1,0,1, 0,32'h00000005,3'd1,1));
    vecs.push_back(mk(1,1,8'hB2,0,1, 0,32'h00000005,3'd1,1));
    vecs.push_back(mk(1,1,8'hC3,1,1, 1,32'h00C3B2A1,3'd3,1));
    vecs.push_back(mk(1,0,8'h00,1,1, 0,32'h00C3B2A1,3'd3,1));
    vecs.push_back(mk(1,0,8'h00,0,1, 0,32'h00C3B2A1,3'd3,1));
    // 5: reset with a pending line and a partial fill
    vecs.push_back(mk(1,1,8'h11,0,0, 0,32'h00C3B2A1,3'd3,1));
    vecs.push_back(mk(1,1,8'h22,0,0, 0,32'h00C3B2A1,3'd3,1));
    vecs.push_back(mk(1,1,8'h33,0,0, 0,32'h00C3B2A1,3'd3,1));
    vecs.push_back(mk(1,1,8'h44,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h55,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(1,1,8'h66,0,0, 1,32'h44332211,3'd4,1));
    vecs.push_back(mk(0,1,8'h77,0,0, 0,32'h0,3'd0,0));
    vecs.push_back(mk(0,1,8'h78,0,1, 0,32'h0,3'd0,0));
    vecs.push_back(mk(1,1,8'h01,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h02,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h03,0,1, 0,32'h0,3'd0,1));
    vecs.push_back(mk(1,1,8'h04,0,1, 1,32'h04030201,3'd4,1));
    vecs.push_back(mk(1,0,8'h00,0,1, 0,32'h04030201,3'd4,1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].d;
      flush = vecs[i].fl; line_ready = vecs[i].lr;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d.line_valid", i), 32'(line_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.line_data", i),  line_data,        vecs[i].e_data);
      check($sformatf("v%0d.line_count", i), 32'(line_count),  32'(vecs[i].e_count));
      check($sformatf("v%0d.in_ready", i),   32'(in_ready),    32'(vecs[i].e_ready));
    end

    // 6: random handshakes against a reference element queue
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; line_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    next_val = 8'h01;
    prev_stall = 1'b0;
    lines_seen = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = next_val;
      line_ready = ($urandom_range(0, 2) == 0) || (c >= 560);
      if (c >= 560) in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        check("stall.line_valid", 32'(line_valid), 32'd1);
        check("stall.line_data", line_data, prev_data);
        check("stall.line_count", 32'(line_count), 32'(prev_count));
      end
      if (line_valid && line_ready) begin
        check("rand.line_count", 32'(line_count), 32'd4);
        if (q.size() < 4) begin
          check("rand.queue_depth", q.size(), 32'd4);
        end else begin
          exp_line = {q[3], q[2], q[1], q[0]};
          for (int k = 0; k < 4; k++) void'(q.pop_front());
          check("rand.line_data", line_data, exp_line);
        end
        lines_seen++;
      end
      prev_stall = line_valid && !line_ready;
      prev_data  = line_data;
      prev_count = line_count;
      if (in_valid && in_ready) begin
        q.push_back(next_val);
        next_val = next_val + 8'h01;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("rand.drained_valid", 32'(line_valid), 32'd0);
    check("rand.leftover_lt4", 32'(q.size() < 4), 32'd1);
    check("rand.lines_seen", 32'(lines_seen > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
